// File: rtl/debug_display_pkg.sv
// Shared types and sizes for the debug 7-segment rate display path.
// Holds the conversion FSM encoding and the binary/BCD widths.
package debug_display_pkg;

   localparam int unsigned BIN_W   = 14;
   localparam int unsigned BCD_W   = 16;
   localparam int unsigned BCD_MAX = 9999;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CONV0 = 2'd1,
      CONV1 = 2'd2,
      DONE  = 2'd3
   } state_e;

endpackage

// File: rtl/bin2bcd_serial.sv
// Serial double-dabble converter: 14-bit binary to 4-digit packed BCD in BIN_W cycles.
// The bcd output already includes the current step, so it is final in the cycle done is high.
module bin2bcd_serial
   import debug_display_pkg::*;
(
   input  logic             clk,
   input  logic             resetn,
   input  logic             start,
   input  logic [BIN_W-1:0] bin,
   output logic [BCD_W-1:0] bcd,
   output logic             done
);

   logic [BIN_W-1:0] sh_q, sh_d;
   logic [BCD_W-1:0] acc_q, acc_d;
   logic [BCD_W-1:0] adj;
   logic [3:0]       cnt_q, cnt_d;

   always_comb begin
      adj = acc_q;
      for (int unsigned i = 0; i < BCD_W / 4; i++) begin
         if (acc_q[4*i +: 4] >= 4'd5) begin
            adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
         end
      end
      bcd  = {adj[BCD_W-2:0], sh_q[BIN_W-1]};
      done = (cnt_q == 4'd1);

      sh_d  = sh_q;
      acc_d = acc_q;
      cnt_d = cnt_q;
      if (start) begin
         sh_d  = bin;
         acc_d = '0;
         cnt_d = 4'(BIN_W);
      end else if (cnt_q != '0) begin
         sh_d  = sh_q << 1;
         acc_d = bcd;
         cnt_d = cnt_q - 4'd1;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         sh_q  <= '0;
         acc_q <= '0;
         cnt_q <= '0;
      end else begin
         sh_q  <= sh_d;
         acc_q <= acc_d;
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/event_rate_bcd.sv
// Counts two event streams per fixed window and publishes the counts as packed BCD
// for the 7-segment display; outputs only change in the single DONE cycle.
module event_rate_bcd
   import debug_display_pkg::*;
#(
   parameter int unsigned WINDOW_CYCLES = 50_000_000,
   parameter int unsigned BCD_MAX       = debug_display_pkg::BCD_MAX
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             event_0,
   input  logic             event_1,
   input  logic             freeze,
   output logic [BCD_W-1:0] number_0,
   output logic [BCD_W-1:0] number_1,
   output logic             update,
   output logic             busy
);

   localparam int unsigned      WIN_W = (WINDOW_CYCLES > 1) ? $clog2(WINDOW_CYCLES) : 1;
   localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW_CYCLES - 1);
   localparam logic [BIN_W-1:0] SAT = BIN_W'(BCD_MAX);

   state_e           state_q, state_d;
   logic [WIN_W-1:0] win_q, win_d;
   logic [BIN_W-1:0] acc0_q, acc0_d, acc1_q, acc1_d;
   logic [BIN_W-1:0] acc0_inc, acc1_inc;
   logic [BIN_W-1:0] snap1_q, snap1_d;
   logic [BCD_W-1:0] res0_q, res0_d, res1_q, res1_d;
   logic [BCD_W-1:0] num0_q, num0_d, num1_q, num1_d;
   logic             update_q, update_d;
   logic             term;

   logic             conv_start;
   logic [BIN_W-1:0] conv_bin;
   logic [BCD_W-1:0] conv_bcd;
   logic             conv_done;

   bin2bcd_serial u_bin2bcd (
      .clk    (clk),
      .resetn (resetn),
      .start  (conv_start),
      .bin    (conv_bin),
      .bcd    (conv_bcd),
      .done   (conv_done)
   );

   always_comb begin
      term     = (win_q == WIN_LAST);
      win_d    = term ? '0 : win_q + WIN_W'(1);
      acc0_inc = (event_0 && acc0_q < SAT) ? acc0_q + BIN_W'(1) : acc0_q;
      acc1_inc = (event_1 && acc1_q < SAT) ? acc1_q + BIN_W'(1) : acc1_q;
      acc0_d   = term ? '0 : acc0_inc;
      acc1_d   = term ? '0 : acc1_inc;
   end

   // Channel 0's snapshot is loaded straight into the converter on term; only
   // channel 1 needs a holding register while channel 0 converts.
   always_comb begin
      state_d    = state_q;
      snap1_d    = snap1_q;
      res0_d     = res0_q;
      res1_d     = res1_q;
      num0_d     = num0_q;
      num1_d     = num1_q;
      update_d   = 1'b0;
      conv_start = 1'b0;
      conv_bin   = snap1_q;

      unique case (state_q)
         IDLE: begin
            if (term) begin
               conv_start = 1'b1;
               conv_bin   = acc0_inc;
               snap1_d    = acc1_inc;
               state_d    = CONV0;
            end
         end
         CONV0: begin
            if (conv_done) begin
               res0_d     = conv_bcd;
               conv_start = 1'b1;
               conv_bin   = snap1_q;
               state_d    = CONV1;
            end
         end
         CONV1: begin
            if (conv_done) begin
               res1_d  = conv_bcd;
               state_d = DONE;
            end
         end
         DONE: begin
            if (!freeze) begin
               num0_d   = res0_q;
               num1_d   = res1_q;
               update_d = 1'b1;
            end
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q  <= IDLE;
         win_q    <= '0;
         acc0_q   <= '0;
         acc1_q   <= '0;
         snap1_q  <= '0;
         res0_q   <= '0;
         res1_q   <= '0;
         num0_q   <= '0;
         num1_q   <= '0;
         update_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         win_q    <= win_d;
         acc0_q   <= acc0_d;
         acc1_q   <= acc1_d;
         snap1_q  <= snap1_d;
         res0_q   <= res0_d;
         res1_q   <= res1_d;
         num0_q   <= num0_d;
         num1_q   <= num1_d;
         update_q <= update_d;
      end
   end

   assign number_0 = num0_q;
   assign number_1 = num1_q;
   assign update   = update_q;
   assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_event_rate_bcd.sv
// Scoreboard bench for event_rate_bcd: a short-window instance for functional cases and a
// long-window instance for saturation and large BCD values; one instance is active at a time.
module tb_event_rate_bcd;

   localparam int W_A = 100;
   localparam int W_B = 20000;

   logic        clk = 1'b0;
   logic        rstn_a, rstn_b;
   logic        e0, e1, frz;
   logic        sel;
   logic        ev0_a, ev1_a, frz_a, ev0_b, ev1_b, frz_b;
   logic [15:0] n0_a, n1_a, n0_b, n1_b;
   logic        upd_a, upd_b, busy_a, busy_b;
   logic [15:0] num0, num1;
   logic        upd, busy;

   always #5 clk = ~clk;

   assign ev0_a = !sel && e0;
   assign ev1_a = !sel && e1;
   assign frz_a = !sel && frz;
   assign ev0_b = sel && e0;
   assign ev1_b = sel && e1;
   assign frz_b = sel && frz;
   assign num0  = sel ? n0_b : n0_a;
   assign num1  = sel ? n1_b : n1_a;
   assign upd   = sel ? upd_b : upd_a;
   assign busy  = sel ? busy_b : busy_a;

   event_rate_bcd #(.WINDOW_CYCLES(W_A), .BCD_MAX(9999)) dut_a (
      .clk(clk), .resetn(rstn_a), .event_0(ev0_a), .event_1(ev1_a), .freeze(frz_a),
      .number_0(n0_a), .number_1(n1_a), .update(upd_a), .busy(busy_a)
   );

   event_rate_bcd #(.WINDOW_CYCLES(W_B), .BCD_MAX(9999)) dut_b (
      .clk(clk), .resetn(rstn_b), .event_0(ev0_b), .event_1(ev1_b), .freeze(frz_b),
      .number_0(n0_b), .number_1(n1_b), .update(upd_b), .busy(busy_b)
   );

   typedef struct {
      logic [15:0] n0;
      logic [15:0] n1;
      int          due;
   } exp_t;

   exp_t        q[$];
   int          cyc;
   int          win;
   int          cnt0, cnt1;
   int          n_chk = 0;
   int          n_pass = 0;
   logic [15:0] disp0, disp1;
   logic        frz_prev;
   bit          mon_en = 1'b0;

   function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h (cycle %0d, dut %0d)", nm, act, exp, cyc, sel);
   endfunction

   // Decimal digits of the saturated count, independent of any shift-add scheme.
   function automatic logic [15:0] to_bcd(input int v);
      int          s;
      logic [15:0] r;
      s = (v > 9999) ? 9999 : v;
      r[15:12] = 4'(s / 1000);
      r[11:8]  = 4'((s / 100) % 10);
      r[7:4]   = 4'((s / 10) % 10);
      r[3:0]   = 4'(s % 10);
      return r;
   endfunction

   task automatic step(input logic a, input logic b, input logic f);
      exp_t it;
      e0  = a;
      e1  = b;
      frz = f;
      if (a) cnt0++;
      if (b) cnt1++;
      if (cyc % win == win - 1) begin
         it.n0  = to_bcd(cnt0);
         it.n1  = to_bcd(cnt1);
         it.due = cyc + 30;
         q.push_back(it);
         cnt0 = 0;
         cnt1 = 0;
      end
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic drive_window(input int k0, input int k1, input int off0, input int off1, input logic f);
      for (int o = 0; o < win; o++)
         step(o >= off0 && o < off0 + k0, o >= off1 && o < off1 + k1, f);
   endtask

   task automatic random_window(input int pct0, input int pct1);
      for (int o = 0; o < win; o++)
         step($urandom_range(99, 0) < pct0, $urandom_range(99, 0) < pct1, 1'b0);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0);
   endtask

   task automatic do_reset(input logic s);
      mon_en = 1'b0;
      e0     = 1'b0;
      e1     = 1'b0;
      frz    = 1'b0;
      rstn_a = 1'b0;
      rstn_b = 1'b0;
      sel    = s;
      win    = s ? W_B : W_A;
      repeat (3) @(posedge clk);
      #1;
      check("reset_number_0", num0, 16'h0000);
      check("reset_number_1", num1, 16'h0000);
      check("reset_update", upd, 1'b0);
      check("reset_busy", busy, 1'b0);
      if (s) rstn_b = 1'b1;
      else rstn_a = 1'b1;
      q.delete();
      cnt0     = 0;
      cnt1     = 0;
      cyc      = 0;
      disp0    = '0;
      disp1    = '0;
      frz_prev = 1'b0;
      mon_en   = 1'b1;
   endtask

   always @(negedge clk) begin
      if (mon_en) begin
         bit due_now;
         bit busy_exp;
         due_now  = (q.size() > 0) && (q[0].due == cyc);
         busy_exp = (q.size() > 0) && (cyc >= q[0].due - 29) && (cyc < q[0].due);
         if (due_now && !frz_prev) begin
            disp0 = q[0].n0;
            disp1 = q[0].n1;
         end
         check("update", upd, due_now && !frz_prev);
         check("number_0", num0, disp0);
         check("number_1", num1, disp1);
         check("busy", busy, busy_exp);
         if (due_now) void'(q.pop_front());
         frz_prev = frz;
      end
   end

   initial begin
      do_reset(1'b0);
      drive_window(37, 5, 2, 50, 1'b0);
      drive_window(0, 0, 0, 0, 1'b0);
      drive_window(1, 0, W_A - 1, 0, 1'b0);
      drive_window(1, 0, 0, 0, 1'b0);
      drive_window(12, 34, 10, 20, 1'b0);
      drive_window(3, 4, 5, 60, 1'b1);
      drive_window(7, 0, 40, 0, 1'b0);
      drive_window(9, 10, 30, 0, 1'b0);
      drive_window(99, 100, 1, 0, 1'b0);
      for (int i = 0; i < 4; i++)
         random_window(int'($urandom_range(90, 5)), int'($urandom_range(90, 5)));

      // Land in CONV1 of the last window, then pull reset asynchronously.
      idle(20);
      mon_en = 1'b0;
      rstn_a = 1'b0;
      #1;
      check("midconv_number_0", num0, 16'h0000);
      check("midconv_number_1", num1, 16'h0000);
      check("midconv_update", upd, 1'b0);
      check("midconv_busy", busy, 1'b0);
      do_reset(1'b0);
      drive_window(55, 21, 3, 70, 1'b0);
      idle(31);
      check("queue_drained_a", q.size(), 0);

      do_reset(1'b1);
      drive_window(9998, 999, 0, 0, 1'b0);
      drive_window(9999, 1000, 5, 5, 1'b0);
      drive_window(W_B, 0, 0, 0, 1'b0);
      idle(31);
      check("queue_drained_b", q.size(), 0);

      mon_en = 1'b0;
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
